// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// UNROLL bits per cycle, stalls execute while it iterates.
module rv_muldiv_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            x_stall_i,
   input  logic            x_kill_i,
   input  logic            d_valid_i,
   input  logic            d_is_muldiv_i,
   input  logic [2:0]      d_fun_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            x_stall_req_o,
   output logic [XLEN-1:0] result_o,
   output logic            result_valid_o,
   output logic            busy_o
);

   localparam int ITERS = XLEN / UNROLL;
   localparam int CNT_W = $clog2(ITERS + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [2:0]        fun_q;
   logic              a_neg_q, b_neg_q;
   logic [XLEN-1:0]   b_q;
   logic [XLEN:0]     acc_q;
   logic [XLEN-1:0]   lo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   result_q;

   logic              start;
   logic              sgn1, sgn2, a_sign, b_sign;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   // ---------------- decode of the incoming op ----------------
   assign start = d_valid_i & d_is_muldiv_i & ~x_kill_i & (state_q == S_IDLE);

   always_comb begin
      sgn1        = 1'b0;
      sgn2        = 1'b0;
      special_res = '0;
      case (d_fun_i)
         3'd0, 3'd1, 3'd4, 3'd6: begin sgn1 = 1'b1; sgn2 = 1'b1; end
         3'd2:                   sgn1 = 1'b1;
         default: ;
      endcase
      a_sign   = sgn1 & rs1_i[XLEN-1];
      b_sign   = sgn2 & rs2_i[XLEN-1];
      abs_a    = a_sign ? -rs1_i : rs1_i;
      abs_b    = b_sign ? -rs2_i : rs2_i;
      div_zero = d_fun_i[2] & (rs2_i == '0);
      div_ovf  = d_fun_i[2] & ~d_fun_i[0] & (rs1_i == XMIN) & (rs2_i == '1);
      special  = div_zero | div_ovf;
      // fun[1] separates REM/REMU from DIV/DIVU
      if (div_zero)
         special_res = d_fun_i[1] ? rs1_i : '1;
      else if (div_ovf)
         special_res = d_fun_i[1] ? '0 : XMIN;
   end

   // ---------------- UNROLL iterations of the datapath ----------------
   logic [XLEN:0]     acc_t, sum_t, diff_t;
   logic [XLEN-1:0]   lo_t;

   always_comb begin
      acc_t  = acc_q;
      lo_t   = lo_q;
      sum_t  = '0;
      diff_t = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (!fun_q[2]) begin
            // multiplier sits in lo and shifts out LSB-first while product bits shift in
            sum_t = {1'b0, acc_t[XLEN-1:0]} + (lo_t[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
            lo_t  = {sum_t[0], lo_t[XLEN-1:1]};
            acc_t = {1'b0, sum_t[XLEN:1]};
         end else begin
            acc_t  = {acc_t[XLEN-1:0], lo_t[XLEN-1]};
            lo_t   = {lo_t[XLEN-2:0], 1'b0};
            diff_t = acc_t - {1'b0, b_q};
            if (!diff_t[XLEN]) begin
               acc_t   = diff_t;
               lo_t[0] = 1'b1;
            end
         end
      end
   end

   // ---------------- sign fixup and result selection ----------------
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, res_t;

   always_comb begin
      prod   = {acc_t[XLEN-1:0], lo_t};
      prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
      quo_s  = (a_neg_q ^ b_neg_q) ? -lo_t : lo_t;
      rem_s  = a_neg_q ? -acc_t[XLEN-1:0] : acc_t[XLEN-1:0];
      case (fun_q)
         3'd0:             res_t = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: res_t = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       res_t = quo_s;
         default:          res_t = rem_s;
      endcase
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d       = state_q;
      x_stall_req_o = start;
      case (state_q)
         S_IDLE: if (start) state_d = special ? S_DONE : S_CALC;
         S_CALC: begin
            x_stall_req_o = ~x_kill_i;
            if (x_kill_i)              state_d = S_IDLE;
            else if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: if (x_kill_i || !x_stall_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         fun_q    <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (start) begin
               fun_q   <= d_fun_i;
               a_neg_q <= a_sign;
               b_neg_q <= b_sign;
               b_q     <= abs_b;
               acc_q   <= '0;
               lo_q    <= abs_a;
               cnt_q   <= CNT_LOAD;
               if (special) result_q <= special_res;
            end
            S_CALC: if (!x_kill_i) begin
               acc_q <= acc_t;
               lo_q  <= lo_t;
               cnt_q <= cnt_q - CNT_LAST;
               if (cnt_q == CNT_LAST) result_q <= res_t;
            end
            default: ;
         endcase
      end
   end

   assign result_o       = result_q;
   assign result_valid_o = (state_q == S_DONE);
   assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Randomized bench for rv_muldiv_iter (UNROLL=1 and UNROLL=4 instances)
// against a plain-arithmetic RV32M reference model.
module tb_rv_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tb_stall = 1'b0;
   logic        kill = 1'b0;
   logic        dv1 = 1'b0, dv4 = 1'b0;
   logic        is_md = 1'b1;
   logic [2:0]  fun = '0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        use4 = 1'b0;

   logic        req1, val1, busy1, req4, val4, busy4;
   logic [31:0] res1, res4;
   logic        xs1, xs4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign xs1 = tb_stall | req1;
   assign xs4 = tb_stall | req4;

   rv_muldiv_iter #(.XLEN(32), .UNROLL(1)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(xs1), .x_kill_i(kill),
      .d_valid_i(dv1), .d_is_muldiv_i(is_md), .d_fun_i(fun),
      .rs1_i(rs1), .rs2_i(rs2), .x_stall_req_o(req1), .result_o(res1),
      .result_valid_o(val1), .busy_o(busy1));

   rv_muldiv_iter #(.XLEN(32), .UNROLL(4)) u4 (
      .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(xs4), .x_kill_i(1'b0),
      .d_valid_i(dv4), .d_is_muldiv_i(is_md), .d_fun_i(fun),
      .rs1_i(rs1), .rs2_i(rs2), .x_stall_req_o(req4), .result_o(res4),
      .result_valid_o(val4), .busy_o(busy4));

   wire        s_req  = use4 ? req4  : req1;
   wire        s_val  = use4 ? val4  : val1;
   wire        s_busy = use4 ? busy4 : busy1;
   wire [31:0] s_res  = use4 ? res4  : res1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] sa, sb, p;
      bit s1, s2;
      s1 = (f == 3'd1 || f == 3'd2);
      s2 = (f == 3'd1);
      sa = s1 ? {{34{a[31]}}, a} : {34'b0, a};
      sb = s2 ? {{34{b[31]}}, b} : {34'b0, b};
      p  = sa * sb;
      case (f)
         3'd0:             return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         default: begin
            if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
            if (is_special(f, a, b)) return f[1] ? 32'h0 : 32'h8000_0000;
            case (f)
               3'd4:    return $signed(a) / $signed(b);
               3'd5:    return a / b;
               3'd6:    return $signed(a) % $signed(b);
               default: return a % b;
            endcase
         end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int exp_st, st, n, vc;
      exp    = ref_op(f, a, b);
      exp_st = is_special(f, a, b) ? 1 : (use4 ? 9 : 33);
      @(negedge clk);
      fun = f; rs1 = a; rs2 = b;
      if (use4) dv4 = 1'b1; else dv1 = 1'b1;
      #1 st = s_req ? 1 : 0;
      @(negedge clk);
      dv1 = 1'b0; dv4 = 1'b0;
      n = 0;
      while (!s_val && n < 100) begin
         if (s_req) st++;
         @(negedge clk);
         n++;
      end
      chk("done_seen", {63'b0, s_val}, 64'd1);
      chk("stall_cycles", st, exp_st);
      chk($sformatf("result f%0d %h %h", f, a, b), s_res, exp);
      vc = 0;
      while (s_val && vc < 20) begin
         vc++;
         chk("res_stable", s_res, exp);
         chk("req_in_done", {63'b0, s_req}, 64'd0);
         tb_stall = (vc <= hold);
         // keep presenting an op while held in DONE: it must not restart
         if (use4) dv4 = tb_stall; else dv1 = tb_stall;
         @(negedge clk);
      end
      tb_stall = 1'b0; dv1 = 1'b0; dv4 = 1'b0;
      chk("valid_cycles", vc, hold + 1);
      chk("idle_after", {63'b0, s_busy}, 64'd0);
   endtask

   function automatic logic [31:0] rnd_val(input int mode);
      case (mode)
         0: return $urandom_range(0, 200);
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_result", res1, 0);
      chk("rst_valid", {63'b0, val1}, 0);
      chk("rst_busy", {63'b0, busy1}, 0);
      chk("rst_req", {63'b0, req1}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd5, 32'd100, 32'd7, 0);
      run_op(3'd7, 32'd100, 32'd7, 0);
      run_op(3'd4, -32'sd100, 32'd7, 0);
      run_op(3'd6, -32'sd100, 32'd7, 0);
      run_op(3'd4, 32'd5, 32'd0, 0);
      run_op(3'd6, 32'd5, 32'd0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 3);

      // kill at CALC cycle 10
      @(negedge clk);
      fun = 3'd0; rs1 = 32'h1234; rs2 = 32'h5678; dv1 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      repeat (9) @(negedge clk);
      chk("kill_busy_before", {63'b0, busy1}, 1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_busy", {63'b0, busy1}, 0);
      chk("kill_req", {63'b0, req1}, 0);
      for (int i = 0; i < 5; i++) begin
         chk("kill_noval", {63'b0, val1}, 0);
         @(negedge clk);
      end

      // reset mid-CALC
      fun = 3'd4; rs1 = 32'hFFFF_0000; rs2 = 32'd9; dv1 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_result", res1, 0);
      chk("rstmid_valid", {63'b0, val1}, 0);
      chk("rstmid_busy", {63'b0, busy1}, 0);
      chk("rstmid_req", {63'b0, req1}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // random traffic, UNROLL=1
      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), rnd_val($urandom_range(0, 7)),
                rnd_val($urandom_range(0, 7)), $urandom_range(0, 2));

      // UNROLL=4 instance
      use4 = 1'b1;
      run_op(3'd5, 32'd100, 32'd7, 0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(3'd6, 32'd5, 32'd0, 1);
      for (int i = 0; i < 15; i++)
         run_op(3'($urandom_range(0, 7)), rnd_val($urandom_range(0, 7)),
                rnd_val($urandom_range(0, 7)), $urandom_range(0, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
